tlb_access_arbiter: RTL and testbench

- Sequences the shared, single-lookup-port TLB between three requesters:
  - instruction fetch translation requests
  - data load/store translation requests
  - CP0 management ops: TLBP, TLBR, TLBWI, TLBWR
- Arbitrates lookups, tracks in-flight lookups so responses route back in order, and drains the TLB before any management op.
- Owns the CP0 Random counter that indexes TLBWR.

---
 rtl/tlb_access_arbiter.sv | 275 +++++++++++++++++++++++++++
 tb/tb_tlb_access_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tlb_access_arbiter
// Purpose  : Shares the TLB's single lookup port between instruction fetch,
//            data load/store and CP0 management ops (TLBP/TLBR/TLBWI/TLBWR).
//            Lookups are arbitrated round-robin. A tag FIFO records the source
//            of each in-flight lookup so that in-order TLB responses are
//            routed back to the right requester. Management ops wait until
//            every in-flight lookup has drained. The block also owns the CP0
//            Random counter that indexes TLBWR.
// Ports    : clk, rst (async, active high)
//            inst_req_*/inst_resp_valid   fetch lookup channel
//            data_req_*/data_resp_valid   data lookup channel
//            mgmt_*                       CP0 management op channel
//            cp0_wired*, random_out       CP0 Wired input / Random output
//            tlb_lkp_*, tlb_mgmt_*        TLB-facing lookup and management
//            protocol_err                 sticky: response with none in flight
// Options  : define DATA_PRIORITY_EN so that data always beats inst when both
//            requesters are valid (no round-robin pointer is built).
// Revision : 1.0 - initial release
// ============================================================================
module tlb_access_arbiter #(
    parameter int TLB_ENTRIES     = 32,
    parameter int IDXW            = $clog2(TLB_ENTRIES),
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_req_valid,
    output logic            inst_req_ready,
    input  logic [31:0]     inst_vaddr,
    output logic            inst_resp_valid,
    input  logic            data_req_valid,
    output logic            data_req_ready,
    input  logic [31:0]     data_vaddr,
    input  logic            data_wr,
    output logic            data_resp_valid,
    input  logic            mgmt_valid,
    input  logic [1:0]      mgmt_op,
    input  logic [IDXW-1:0] mgmt_index,
    output logic            mgmt_ready,
    output logic            mgmt_done,
    input  logic [IDXW-1:0] cp0_wired,
    input  logic            cp0_wired_we,
    output logic [IDXW-1:0] random_out,
    output logic            tlb_lkp_valid,
    output logic [31:0]     tlb_lkp_vaddr,
    output logic            tlb_lkp_wr,
    input  logic            tlb_lkp_resp_valid,
    output logic            tlb_mgmt_valid,
    output logic [1:0]      tlb_mgmt_op,
    output logic [IDXW-1:0] tlb_mgmt_index,
    input  logic            tlb_mgmt_ack,
    output logic            protocol_err
);

    localparam int PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNTW = $clog2(MAX_OUTSTANDING) + 1;

    localparam logic [IDXW-1:0] RAND_TOP = IDXW'(TLB_ENTRIES - 1);
    localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(MAX_OUTSTANDING);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_MGMT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]                 state_q,   state_d;
    logic [CNTW-1:0]            count_q,   count_d;
    logic [PTRW-1:0]            wr_ptr_q,  wr_ptr_d;
    logic [PTRW-1:0]            rd_ptr_q,  rd_ptr_d;
    logic [MAX_OUTSTANDING-1:0] tag_q,     tag_d;     // 0 = inst, 1 = data
    logic [1:0]                 op_q,      op_d;
    logic [IDXW-1:0]            index_q,   index_d;
    logic [IDXW-1:0]            random_q,  random_d;
    logic                       err_q,     err_d;
`ifndef DATA_PRIORITY_EN
    logic                       last_data_q, last_data_d;  // 1 = data won last
`endif

    logic lkp_ok;
    logic resp_pop;
    logic grant_inst;
    logic grant_data;
    logic lkp_push;
    logic head_src;

    // ------------------------------------------------------------------------
    // Lookup arbitration
    // ------------------------------------------------------------------------
    always_comb begin
        resp_pop = tlb_lkp_resp_valid && (count_q != '0);
        // A response popping this cycle frees a slot, so a full tracker can
        // still accept a new lookup in the same cycle.
        lkp_ok   = !rst && (state_q == S_IDLE) && !mgmt_valid &&
                   ((count_q < CNT_MAX) || resp_pop);
`ifdef DATA_PRIORITY_EN
        grant_data = lkp_ok && data_req_valid;
        grant_inst = lkp_ok && inst_req_valid && !data_req_valid;
`else
        grant_inst = lkp_ok && inst_req_valid && (!data_req_valid || last_data_q);
        grant_data = lkp_ok && data_req_valid && !grant_inst;
`endif
        lkp_push = grant_inst || grant_data;
    end

    assign inst_req_ready = grant_inst;
    assign data_req_ready = grant_data;
    assign tlb_lkp_valid  = lkp_push;
    assign tlb_lkp_vaddr  = grant_data ? data_vaddr : inst_vaddr;
    assign tlb_lkp_wr     = grant_data && data_wr;

    // ------------------------------------------------------------------------
    // Response routing from the tag FIFO head
    // ------------------------------------------------------------------------
    assign head_src        = tag_q[rd_ptr_q];
    assign inst_resp_valid = resp_pop && !head_src;
    assign data_resp_valid = resp_pop &&  head_src;

    // ------------------------------------------------------------------------
    // Tag FIFO, outstanding count, sticky protocol error
    // ------------------------------------------------------------------------
    always_comb begin
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q || (tlb_lkp_resp_valid && (count_q == '0));

        // Pointers wrap naturally because the depth is a power of two. When
        // full with a simultaneous push/pop, wr and rd hit the same slot; the
        // head is read from the old value before the write lands.
        if (lkp_push) begin
            tag_d[wr_ptr_q] = grant_data;
            wr_ptr_d        = wr_ptr_q + PTRW'(1);
        end
        if (resp_pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end

        case ({lkp_push, resp_pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

`ifndef DATA_PRIORITY_EN
    always_comb begin
        last_data_d = last_data_q;
        if (lkp_push) begin
            last_data_d = grant_data;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Management sequencing
    // ------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        index_d        = index_q;
        mgmt_ready     = 1'b0;
        tlb_mgmt_valid = 1'b0;
        mgmt_done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                mgmt_ready = !rst && (count_q == '0);
                if (mgmt_valid) begin
                    if (count_q == '0) begin
                        state_d = S_MGMT;
                        op_d    = mgmt_op;
                        case (mgmt_op)
                            OP_TLBWR: index_d = random_q;
                            OP_TLBR,
                            OP_TLBWI: index_d = mgmt_index;
                            OP_TLBP:  index_d = '0;
                            default:  index_d = '0;
                        endcase
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            // Acceptance happens back in IDLE so it always sees a clean,
            // empty tracker.
            S_DRAIN: begin
                if (count_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_MGMT: begin
                tlb_mgmt_valid = 1'b1;
                if (tlb_mgmt_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                mgmt_done = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tlb_mgmt_op    = op_q;
    assign tlb_mgmt_index = index_q;

    // ------------------------------------------------------------------------
    // CP0 Random: counts down from the top to Wired, then wraps to the top.
    // A Wired value at or above the top pins Random at the top.
    // ------------------------------------------------------------------------
    always_comb begin
        if (cp0_wired_we || (cp0_wired >= RAND_TOP) || (random_q == cp0_wired)) begin
            random_d = RAND_TOP;
        end else begin
            random_d = random_q - IDXW'(1);
        end
    end

    assign random_out   = random_q;
    assign protocol_err = err_q;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tag_q    <= '0;
            op_q     <= OP_TLBP;
            index_q  <= '0;
            random_q <= RAND_TOP;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tag_q    <= tag_d;
            op_q     <= op_d;
            index_q  <= index_d;
            random_q <= random_d;
            err_q    <= err_d;
        end
    end

`ifndef DATA_PRIORITY_EN
    // Reset value makes inst the favoured requester on the first conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_data_q <= 1'b1;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlb_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlb_access_arbiter
// Purpose  : Self-checking bench for tlb_access_arbiter. A reference model
//            (queue of in-flight sources, last-winner flag, Random rule)
//            predicts grants; expected response routing is queued and checked
//            by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlb_access_arbiter;

    localparam int TLB_ENTRIES = 32;
    localparam int IDXW        = 5;
    localparam int MAXO        = 4;

    logic            clk;
    logic            rst;
    logic            inst_req_valid;
    logic            inst_req_ready;
    logic [31:0]     inst_vaddr;
    logic            inst_resp_valid;
    logic            data_req_valid;
    logic            data_req_ready;
    logic [31:0]     data_vaddr;
    logic            data_wr;
    logic            data_resp_valid;
    logic            mgmt_valid;
    logic [1:0]      mgmt_op;
    logic [IDXW-1:0] mgmt_index;
    logic            mgmt_ready;
    logic            mgmt_done;
    logic [IDXW-1:0] cp0_wired;
    logic            cp0_wired_we;
    logic [IDXW-1:0] random_out;
    logic            tlb_lkp_valid;
    logic [31:0]     tlb_lkp_vaddr;
    logic            tlb_lkp_wr;
    logic            tlb_lkp_resp_valid;
    logic            tlb_mgmt_valid;
    logic [1:0]      tlb_mgmt_op;
    logic [IDXW-1:0] tlb_mgmt_index;
    logic            tlb_mgmt_ack;
    logic            protocol_err;

    tlb_access_arbiter #(
        .TLB_ENTRIES     (TLB_ENTRIES),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .inst_req_valid     (inst_req_valid),
        .inst_req_ready     (inst_req_ready),
        .inst_vaddr         (inst_vaddr),
        .inst_resp_valid    (inst_resp_valid),
        .data_req_valid     (data_req_valid),
        .data_req_ready     (data_req_ready),
        .data_vaddr         (data_vaddr),
        .data_wr            (data_wr),
        .data_resp_valid    (data_resp_valid),
        .mgmt_valid         (mgmt_valid),
        .mgmt_op            (mgmt_op),
        .mgmt_index         (mgmt_index),
        .mgmt_ready         (mgmt_ready),
        .mgmt_done          (mgmt_done),
        .cp0_wired          (cp0_wired),
        .cp0_wired_we       (cp0_wired_we),
        .random_out         (random_out),
        .tlb_lkp_valid      (tlb_lkp_valid),
        .tlb_lkp_vaddr      (tlb_lkp_vaddr),
        .tlb_lkp_wr         (tlb_lkp_wr),
        .tlb_lkp_resp_valid (tlb_lkp_resp_valid),
        .tlb_mgmt_valid     (tlb_mgmt_valid),
        .tlb_mgmt_op        (tlb_mgmt_op),
        .tlb_mgmt_index     (tlb_mgmt_index),
        .tlb_mgmt_ack       (tlb_mgmt_ack),
        .protocol_err       (protocol_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model state ----------------
    int        passed = 0;
    int        total  = 0;
    bit        inflight[$];   // sources of in-flight lookups, oldest first
    bit        exp_q[$];      // expected response routing, 0 inst / 1 data
    int        grants[$];     // log of grant winners
    bit        last_data = 1'b1;
    bit        busy      = 1'b0;
    logic [IDXW-1:0] rnd_model;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Random: counts down to Wired then restarts at the top; a write to Wired
    // or a Wired value at/over the top gives the top value.
    always @(posedge clk or posedge rst) begin
        if (rst) rnd_model <= IDXW'(TLB_ENTRIES - 1);
        else if (cp0_wired_we || cp0_wired >= IDXW'(TLB_ENTRIES - 1) || rnd_model == cp0_wired)
            rnd_model <= IDXW'(TLB_ENTRIES - 1);
        else
            rnd_model <= rnd_model - 1'b1;
    end

    // Monitor: whenever a response is expected or presented, compare routing.
    initial begin
        bit e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("resp_route", {30'd0, inst_resp_valid, data_resp_valid}, e ? 32'd1 : 32'd2);
            end else if (inst_resp_valid || data_resp_valid) begin
                chk("resp_spurious", {30'd0, inst_resp_valid, data_resp_valid}, 32'd0);
            end
        end
    end

    // One cycle of lookup-side stimulus, driven at the negedge. Checks the
    // combinational grant outputs against the model and updates the model.
    task automatic step(input bit iv, input bit dv, input bit resp);
        logic [31:0] ia, da;
        bit dw, pop_ok, elig, gi, gd;
        ia = $urandom;
        da = $urandom;
        dw = 1'($urandom_range(0, 1));
        inst_req_valid     = iv;
        data_req_valid     = dv;
        inst_vaddr         = ia;
        data_vaddr         = da;
        data_wr            = dw;
        tlb_lkp_resp_valid = resp;
        #1;
        pop_ok = resp && (inflight.size() > 0);
        elig   = !mgmt_valid && !busy && ((inflight.size() < MAXO) || pop_ok);
`ifdef DATA_PRIORITY_EN
        gd = elig && dv;
        gi = elig && iv && !dv;
`else
        gi = elig && iv && (!dv || last_data);
        gd = elig && dv && !gi;
`endif
        chk("inst_req_ready", {31'd0, inst_req_ready}, {31'd0, gi});
        chk("data_req_ready", {31'd0, data_req_ready}, {31'd0, gd});
        chk("tlb_lkp_valid", {31'd0, tlb_lkp_valid}, {31'd0, gi | gd});
        if (gi || gd) begin
            chk("tlb_lkp_vaddr", tlb_lkp_vaddr, gd ? da : ia);
            chk("tlb_lkp_wr", {31'd0, tlb_lkp_wr}, {31'd0, gd & dw});
        end
        if (pop_ok) exp_q.push_back(inflight.pop_front());
        if (gi || gd) begin
            inflight.push_back(gd);
            grants.push_back(gd ? 1 : 0);
            last_data = gd;
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Runs one management op: waits (bounded) for acceptance while offering
    // lookups, then holds until ack after ack_delay cycles, then checks done.
    task automatic do_mgmt(input logic [1:0] op, input logic [IDXW-1:0] idx, input int ack_delay);
        logic [IDXW-1:0] exp_idx;
        bit accepted;
        accepted   = 1'b0;
        exp_idx    = '0;
        mgmt_valid = 1'b1;
        mgmt_op    = op;
        mgmt_index = idx;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, (i >= 2) && (inflight.size() > 0));
            if (mgmt_ready) begin
                chk("mgmt_ready_drained", inflight.size(), 0);
                case (op)
                    2'b11:   exp_idx = rnd_model;
                    2'b00:   exp_idx = '0;
                    default: exp_idx = idx;
                endcase
                accepted = 1'b1;
                nxt();
                break;
            end
            nxt();
        end
        if (!accepted) chk("mgmt_accept_timeout", 0, 1);
        mgmt_valid = 1'b0;
        mgmt_index = '0;
        busy       = 1'b1;
        for (int k = 0; k <= ack_delay; k++) begin
            tlb_mgmt_ack = (k == ack_delay);
            step(1'b1, 1'b0, 1'b0);
            chk("tlb_mgmt_valid", {31'd0, tlb_mgmt_valid}, 32'd1);
            chk("tlb_mgmt_op", {30'd0, tlb_mgmt_op}, {30'd0, op});
            chk("tlb_mgmt_index", {27'd0, tlb_mgmt_index}, {27'd0, exp_idx});
            chk("mgmt_done_early", {31'd0, mgmt_done}, 32'd0);
            nxt();
        end
        tlb_mgmt_ack = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        chk("mgmt_done", {31'd0, mgmt_done}, 32'd1);
        chk("tlb_mgmt_valid_off", {31'd0, tlb_mgmt_valid}, 32'd0);
        nxt();
        busy = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk("mgmt_done_pulse", {31'd0, mgmt_done}, 32'd0);
        nxt();
    endtask

    task automatic drain();
        for (int i = 0; i < 16 && inflight.size() > 0; i++) begin
            step(1'b0, 1'b0, 1'b1);
            nxt();
        end
        chk("drain_empty", inflight.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seq[10];
        int rr_exp[4];
        seq = '{31, 30, 29, 28, 31, 30, 29, 28, 31, 30};
`ifdef DATA_PRIORITY_EN
        rr_exp = '{1, 1, 1, 1};
`else
        rr_exp = '{0, 1, 0, 1};
`endif
        rst = 1'b1;
        inst_req_valid = 1'b1; data_req_valid = 1'b1;
        inst_vaddr = '0; data_vaddr = '0; data_wr = 1'b0;
        mgmt_valid = 1'b0; mgmt_op = 2'b00; mgmt_index = '0;
        cp0_wired = 5'd28; cp0_wired_we = 1'b0;
        tlb_lkp_resp_valid = 1'b0; tlb_mgmt_ack = 1'b0;

        // Reset values while reset is held
        nxt();
        #1;
        chk("rst_inst_ready", {31'd0, inst_req_ready}, 32'd0);
        chk("rst_data_ready", {31'd0, data_req_ready}, 32'd0);
        chk("rst_lkp_valid", {31'd0, tlb_lkp_valid}, 32'd0);
        chk("rst_mgmt_ready", {31'd0, mgmt_ready}, 32'd0);
        chk("rst_mgmt_valid", {31'd0, tlb_mgmt_valid}, 32'd0);
        chk("rst_mgmt_done", {31'd0, mgmt_done}, 32'd0);
        chk("rst_protocol_err", {31'd0, protocol_err}, 32'd0);
        chk("rst_random", {27'd0, random_out}, 32'd31);
        nxt();
        rst = 1'b0;

        // Random counter sequence with Wired = 28
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("random_seq", {27'd0, random_out}, seq[i]);
            nxt();
        end
        cp0_wired_we = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        nxt();
        cp0_wired_we = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk("random_after_we", {27'd0, random_out}, 32'd31);
        nxt();
        cp0_wired = 5'd31;
        step(1'b0, 1'b0, 1'b0);
        nxt();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("random_hold", {27'd0, random_out}, 32'd31);
            chk("random_model", {27'd0, random_out}, {27'd0, rnd_model});
            nxt();
        end
        cp0_wired = 5'd3;

        // Both requesters valid, TLB with 1-cycle response latency
        grants.delete();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, inflight.size() > 0);
            nxt();
        end
        for (int i = 0; i < 4; i++) chk("rr_order", grants.size() > i ? grants[i] : -1, rr_exp[i]);
        drain();

        // Fill the tracker with data lookups, then grant on a response
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0);
            nxt();
        end
        step(1'b0, 1'b1, 1'b0);
        chk("full_blocks", {31'd0, data_req_ready}, 32'd0);
        nxt();
        step(1'b0, 1'b1, 1'b1);
        chk("grant_on_resp", {31'd0, data_req_ready}, 32'd1);
        nxt();
        drain();

        // Interleaved inst, data, inst then three responses
        step(1'b1, 1'b0, 1'b0); nxt();
        step(1'b0, 1'b1, 1'b0); nxt();
        step(1'b1, 1'b0, 1'b0); nxt();
        drain();

        // TLBWI index 5 with two lookups outstanding
        step(1'b1, 1'b0, 1'b0); nxt();
        step(1'b0, 1'b1, 1'b0); nxt();
        do_mgmt(2'b10, 5'd5, 2);

        // Randomized lookup traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) != 0) && (inflight.size() > 0));
            nxt();
        end
        drain();

        // TLBWR uses Random at acceptance; TLBP forces 0; TLBR uses Index
        do_mgmt(2'b11, 5'd9, 0);
        do_mgmt(2'b00, 5'd7, 1);
        do_mgmt(2'b01, 5'd12, 3);

        // Reset mid-operation, then a late response
        step(1'b1, 1'b0, 1'b0);
        nxt();
        rst = 1'b1;
        inflight.delete();
        last_data = 1'b1;
        #1;
        chk("midrst_err", {31'd0, protocol_err}, 32'd0);
        nxt();
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        nxt();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("protocol_err_sticky", {31'd0, protocol_err}, 32'd1);
            nxt();
        end
        rst = 1'b1;
        #1;
        chk("rst_clears_err", {31'd0, protocol_err}, 32'd0);
        chk("rst_random_top", {27'd0, random_out}, 32'd31);
        nxt();
        rst = 1'b0;
        nxt();
        #5;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
